// File: rtl/regfile_arb_pkg.sv
// Shared widths, arbitration state encoding and default starvation limit.
package regfile_arb_pkg;
    localparam int XLEN                 = 32;
    localparam int REG_AW               = 5;
    localparam int NREGS                = 1 << REG_AW;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } arb_state_t;

    function automatic logic [NREGS-1:0] addr_mask(input logic [REG_AW-1:0] a);
        return NREGS'(1) << a;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for long-latency destinations with read-hazard and issue-conflict lookups.
// Lookups are combinational; busy bits update one edge after set/clear; no backpressure.
module regfile_scoreboard
    import regfile_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              set_vld_i,
    input  logic [REG_AW-1:0] set_addr_i,
    input  logic              clr_vld_i,
    input  logic [REG_AW-1:0] clr_addr_i,
    input  logic [REG_AW-1:0] issue_addr_i,
    input  logic [REG_AW-1:0] raddr1_i,
    input  logic [REG_AW-1:0] raddr2_i,
    input  logic              wr_pend_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    output logic              issue_conflict_o,
    output logic              hazard1_o,
    output logic              hazard2_o
);
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld_i && (set_addr_i != '0)) set_mask = addr_mask(set_addr_i);
        if (clr_vld_i) clr_mask = addr_mask(clr_addr_i);
        // Set is applied after clear so a same-cycle reissue keeps the bit.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        issue_conflict_o = busy_q[issue_addr_i];
        hazard1_o = (raddr1_i != '0) &&
                    (busy_q[raddr1_i] || (wr_pend_i && (wr_addr_i == raddr1_i)));
        hazard2_o = (raddr2_i != '0) &&
                    (busy_q[raddr2_i] || (wr_pend_i && (wr_addr_i == raddr2_i)));
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates pipeline (A) and long-latency (B) writebacks onto one registered regfile write port.
// Latency 1; A never backpressured, B held via b_ready and anti-starved by a one-cycle pipeline stall.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [REG_AW-1:0] a_waddr,
    input  logic [XLEN-1:0]   a_wdata,
    input  logic              b_valid,
    input  logic [REG_AW-1:0] b_waddr,
    input  logic [XLEN-1:0]   b_wdata,
    output logic              b_ready,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_waddr,
    output logic              issue_conflict,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic              hazard1,
    output logic              hazard2,
    output logic              stall_pipe,
    output logic              reg_wr,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata
);
    localparam int CNT_W = 4;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              reg_wr_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;

    logic              grant_a, grant_b;
    logic              wr_vld;
    logic [REG_AW-1:0] wr_addr_sel;
    logic [XLEN-1:0]   wr_data_sel;
    logic              b_hs;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        b_ready    = 1'b0;
        stall_pipe = 1'b0;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        if (!rst) begin
            case (state_q)
                NORMAL: begin
                    b_ready = !a_valid;
                    grant_a = a_valid;
                    grant_b = b_valid && !a_valid;
                    if (b_valid && a_valid) begin
                        if (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1)) state_d = STARVE;
                        else wait_cnt_d = wait_cnt_q + 4'd1;
                    end
                end
                STARVE: begin
                    // A is held off for this cycle; B either drains or has gone away.
                    stall_pipe = 1'b1;
                    b_ready    = 1'b1;
                    grant_b    = b_valid;
                    state_d    = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
        end
        b_hs        = b_valid && b_ready;
        wr_vld      = grant_a || grant_b;
        wr_addr_sel = grant_a ? a_waddr : b_waddr;
        wr_data_sel = grant_a ? a_wdata : b_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= NORMAL;
            wait_cnt_q <= '0;
            reg_wr_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            reg_wr_q   <= wr_vld && (wr_addr_sel != '0);
            if (wr_vld) begin
                waddr_q <= wr_addr_sel;
                wdata_q <= wr_data_sel;
            end
        end
    end

    assign reg_wr = reg_wr_q;
    assign waddr  = waddr_q;
    assign wdata  = wdata_q;

    regfile_scoreboard u_scoreboard (
        .clk              (clk),
        .rst              (rst),
        .set_vld_i        (issue_valid),
        .set_addr_i       (issue_waddr),
        .clr_vld_i        (b_hs),
        .clr_addr_i       (b_waddr),
        .issue_addr_i     (issue_waddr),
        .raddr1_i         (raddr1),
        .raddr2_i         (raddr2),
        .wr_pend_i        (reg_wr_q),
        .wr_addr_i        (waddr_q),
        .issue_conflict_o (issue_conflict),
        .hazard1_o        (hazard1),
        .hazard2_o        (hazard2)
    );
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed vector table, starvation/reset sequences, random traffic.
module tb_regfile_wr_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_waddr, b_waddr, issue_waddr, raddr1, raddr2;
    logic [31:0] a_wdata, b_wdata;
    logic        b_ready, issue_conflict, hazard1, hazard2, stall_pipe, reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_waddr(b_waddr), .b_wdata(b_wdata), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_waddr(issue_waddr), .issue_conflict(issue_conflict),
        .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2),
        .stall_pipe(stall_pipe), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata)
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: starvation flag, count of consecutive blocked B cycles,
    // busy set of registers, and the write currently shown on the output port.
    bit          m_starve;
    int          m_blk;
    bit [31:0]   m_busy;
    bit          m_wr;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    function automatic bit m_hz(input logic [4:0] ra);
        return (ra != 5'd0) && (m_busy[ra] || (m_wr && m_waddr == ra));
    endfunction

    task automatic model_check();
        bit e_brdy;
        e_brdy = rst ? 1'b0 : (m_starve ? 1'b1 : !a_valid);
        chk("m_b_ready",    32'(b_ready),        32'(e_brdy));
        chk("m_stall",      32'(stall_pipe),     32'(!rst && m_starve));
        chk("m_reg_wr",     32'(reg_wr),         32'(m_wr));
        if (m_wr) begin
            chk("m_waddr", 32'(waddr), 32'(m_waddr));
            chk("m_wdata", wdata, m_wdata);
        end
        chk("m_hazard1",    32'(hazard1),        32'(m_hz(raddr1)));
        chk("m_hazard2",    32'(hazard2),        32'(m_hz(raddr2)));
        chk("m_conflict",   32'(issue_conflict), 32'(m_busy[issue_waddr]));
    endtask

    task automatic model_update();
        bit brdy, hs, wr;
        logic [4:0]  wa;
        logic [31:0] wd;
        if (rst) begin
            m_starve = 0; m_blk = 0; m_busy = '0; m_wr = 0; m_waddr = '0; m_wdata = '0;
            return;
        end
        brdy = m_starve ? 1'b1 : !a_valid;
        hs   = b_valid && brdy;
        wr = 1'b0; wa = '0; wd = '0;
        if (!m_starve && a_valid) begin wr = 1'b1; wa = a_waddr; wd = a_wdata; end
        else if (hs)              begin wr = 1'b1; wa = b_waddr; wd = b_wdata; end
        m_wr = wr && (wa != 5'd0);
        if (m_wr) begin m_waddr = wa; m_wdata = wd; end
        if (hs) m_busy[b_waddr] = 1'b0;
        if (issue_valid && issue_waddr != 5'd0) m_busy[issue_waddr] = 1'b1;
        if (b_valid && !brdy) begin
            m_blk++;
            if (m_blk == LIM) begin m_starve = 1; m_blk = 0; end
        end else begin
            m_blk = 0;
            m_starve = 0;
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
        model_check();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 0; a_waddr = '0; a_wdata = '0;
        b_valid = 0; b_waddr = '0; b_wdata = '0;
        issue_valid = 0; issue_waddr = '0; raddr1 = '0; raddr2 = '0;
    endtask

    typedef struct {
        logic a_v; logic [4:0] a_a; logic [31:0] a_d;
        logic b_v; logic [4:0] b_a; logic [31:0] b_d;
        logic i_v; logic [4:0] i_a; logic [4:0] r1; logic [4:0] r2;
        logic e_brdy; logic e_stall; logic e_wr; logic [4:0] e_wa; logic [31:0] e_wd;
        logic e_h1; logic e_h2; logic e_cf;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int k;
        bit was_stall;

        // a_v a_a a_d | b_v b_a b_d | i_v i_a r1 r2 | brdy stall wr wa wd | h1 h2 cf
        tbl[0]  = '{1'b1,5'd5,32'hA5A5A5A5, 1'b0,5'd0,32'h0, 1'b0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0,5'd5,5'd0, 1'b1,1'b0,1'b1,5'd5,32'hA5A5A5A5, 1'b1,1'b0,1'b0};
        tbl[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b1,5'd7,5'd7,5'd0, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd7,5'd7,5'd0, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b1};
        tbl[4]  = '{1'b0,5'd0,32'h0,        1'b1,5'd7,32'h77,1'b0,5'd7,5'd7,5'd0, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b1,1'b0,1'b1};
        tbl[5]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd7,5'd7,5'd0, 1'b1,1'b0,1'b1,5'd7,32'h77,       1'b1,1'b0,1'b0};
        tbl[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0,5'd7,5'd0, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'h99,1'b1,5'd9,5'd0,5'd9, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
        tbl[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd9,5'd0,5'd9, 1'b1,1'b0,1'b1,5'd9,32'h99,       1'b0,1'b1,1'b1};
        tbl[9]  = '{1'b1,5'd0,32'h1234,     1'b0,5'd0,32'h0, 1'b0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b0,1'b0};
        tbl[10] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0, 1'b0,5'd0,5'd0,5'd9, 1'b1,1'b0,1'b0,5'd0,32'h0,        1'b0,1'b1,1'b0};

        // Reset state
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        raddr1 = 5'd7; raddr2 = 5'd9; issue_waddr = 5'd7;
        @(negedge clk);
        chk("rst_reg_wr",   32'(reg_wr),         32'd0);
        chk("rst_waddr",    32'(waddr),          32'd0);
        chk("rst_wdata",    wdata,               32'd0);
        chk("rst_b_ready",  32'(b_ready),        32'd0);
        chk("rst_stall",    32'(stall_pipe),     32'd0);
        chk("rst_hazard1",  32'(hazard1),        32'd0);
        chk("rst_hazard2",  32'(hazard2),        32'd0);
        chk("rst_conflict", 32'(issue_conflict), 32'd0);
        cyc_end();
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            a_valid = tbl[i].a_v; a_waddr = tbl[i].a_a; a_wdata = tbl[i].a_d;
            b_valid = tbl[i].b_v; b_waddr = tbl[i].b_a; b_wdata = tbl[i].b_d;
            issue_valid = tbl[i].i_v; issue_waddr = tbl[i].i_a;
            raddr1 = tbl[i].r1; raddr2 = tbl[i].r2;
            cyc_begin();
            chk($sformatf("v%0d_b_ready", i),  32'(b_ready),        32'(tbl[i].e_brdy));
            chk($sformatf("v%0d_stall", i),    32'(stall_pipe),     32'(tbl[i].e_stall));
            chk($sformatf("v%0d_reg_wr", i),   32'(reg_wr),         32'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tbl[i].e_wa));
                chk($sformatf("v%0d_wdata", i), wdata,      tbl[i].e_wd);
            end
            chk($sformatf("v%0d_hazard1", i),  32'(hazard1),        32'(tbl[i].e_h1));
            chk($sformatf("v%0d_hazard2", i),  32'(hazard2),        32'(tbl[i].e_h2));
            chk($sformatf("v%0d_conflict", i), 32'(issue_conflict), 32'(tbl[i].e_cf));
            cyc_end();
        end

        // Starvation: A and B both valid; A payload advances only when not stalled
        idle_inputs();
        k = 1;
        b_valid = 1'b1; b_waddr = 5'd20; b_wdata = 32'hB0B0;
        for (int c = 0; c < 8; c++) begin
            a_valid = 1'b1; a_waddr = 5'(k); a_wdata = 32'hA000 + 32'(k);
            cyc_begin();
            was_stall = stall_pipe;
            if (c < 4) begin
                chk($sformatf("stv_b_ready_c%0d", c), 32'(b_ready),    32'd0);
                chk($sformatf("stv_stall_c%0d", c),   32'(stall_pipe), 32'd0);
            end
            if (c >= 1 && c <= 4) chk($sformatf("stv_a_waddr_c%0d", c), 32'(waddr), 32'(c));
            if (c == 4) begin
                chk("stv_stall_in_starve", 32'(stall_pipe), 32'd1);
                chk("stv_b_ready_starve",  32'(b_ready),    32'd1);
            end
            if (c == 5) begin
                chk("stv_b_reg_wr", 32'(reg_wr),     32'd1);
                chk("stv_b_waddr",  32'(waddr),      32'd20);
                chk("stv_b_wdata",  wdata,           32'hB0B0);
                chk("stv_stall_c5", 32'(stall_pipe), 32'd0);
            end
            if (c == 6) begin
                chk("stv_a5_waddr", 32'(waddr), 32'd5);
                chk("stv_a5_wdata", wdata,      32'hA005);
            end
            cyc_end();
            if (!was_stall) k++;
        end

        // Reset while in STARVE with a write in flight
        idle_inputs();
        issue_valid = 1'b1; issue_waddr = 5'd12;
        cyc_begin(); cyc_end();
        issue_valid = 1'b0;
        a_valid = 1'b1; a_waddr = 5'd4; a_wdata = 32'h44;
        b_valid = 1'b1; b_waddr = 5'd21; b_wdata = 32'h21;
        repeat (LIM) begin cyc_begin(); cyc_end(); end
        raddr1 = 5'd12; raddr2 = 5'd4;
        @(negedge clk);
        chk("rs_pre_stall",  32'(stall_pipe), 32'd1);
        chk("rs_pre_reg_wr", 32'(reg_wr),     32'd1);
        @(posedge clk); model_update(); #1;
        rst = 1'b1;
        cyc_begin(); cyc_end();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        chk("rs_stall",   32'(stall_pipe), 32'd0);
        chk("rs_reg_wr",  32'(reg_wr),     32'd0);
        chk("rs_hazard1", 32'(hazard1),    32'd0);
        chk("rs_hazard2", 32'(hazard2),    32'd0);
        cyc_end();

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            a_valid     = ($urandom_range(0, 9) < 7);
            a_waddr     = 5'($urandom_range(0, 7));
            a_wdata     = $urandom;
            b_valid     = ($urandom_range(0, 3) != 0);
            b_waddr     = 5'($urandom_range(0, 7));
            b_wdata     = $urandom;
            issue_valid = ($urandom_range(0, 3) == 0);
            issue_waddr = 5'($urandom_range(0, 7));
            raddr1      = 5'($urandom_range(0, 7));
            raddr2      = 5'($urandom_range(0, 7));
            cyc_begin();
            cyc_end();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
